seq_scan_ctrl: RTL and testbench
================================

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, number of bits per word scanned; legal range 4..16.
REQ-002 Parameter: CW, $clog2(WIDTH)+1, width of the per-word match count.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  a parallel word is offered on in_data.
REQ-006 in_data  input  WIDTH  word to scan, serialized MSB first.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 abort  input  1  synchronous; cancels the scan in progress.
REQ-009 out_valid  output  1  out_count holds a valid result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_count  output  CW  number of "1101" matches found in the last word.
REQ-012 total_count  output  16  running total of matches since reset.
REQ-013 ser_bit  output  1  bit currently being fed to the detector; debug only.
REQ-014 busy  output  1  high while in SHIFT or REPORT.

Function
REQ-015 The FSM shall have exactly three states: IDLE, SHIFT and REPORT.
REQ-016 IDLE shall drive in_ready=1; in every other state in_ready shall be 0.
REQ-017 In IDLE, in_valid=1 shall capture in_data into the shift register, clear the 3-bit match history and the word count, set the bit index to 0, and move to SHIFT on that edge.
REQ-018 SHIFT shall consume one bit per cycle, MSB first, for exactly WIDTH cycles; ser_bit shall equal the current MSB of the shift register.
REQ-019 On each SHIFT edge, the word count shall increment when {history[2:0], ser_bit}==4'b1101; the history shall then shift left, taking in ser_bit.
REQ-020 Matches may overlap (bits 1101101 count 2); bits from a previous word shall never take part in a match.
REQ-021 On the edge that consumes bit WIDTH-1, the FSM shall move to REPORT and out_count shall take the final count, including a match on that last bit.
REQ-022 total_count shall add each word's count when the FSM enters REPORT and shall saturate at 16'hFFFF.
REQ-023 In REPORT, out_valid shall be 1 and out_count shall hold steady until out_valid&&out_ready.
REQ-024 When out_valid&&out_ready, the FSM shall return to IDLE on that edge.
REQ-025 A new word shall be accepted no earlier than the cycle after the return to IDLE.
REQ-026 Latency: a word accepted at edge k shall give out_valid=1 immediately after edge k+WIDTH.
REQ-027 Throughput with out_ready tied high: one word per WIDTH+2 cycles.
REQ-028 abort=1 in SHIFT or REPORT shall return the FSM to IDLE on the next edge.
REQ-029 That abort shall leave out_valid=0 and total_count unchanged, counting a word being shifted nothing and a word in REPORT no further.
REQ-030 abort in IDLE shall be ignored, and abort shall take priority over in_valid in the same cycle.
REQ-031 out_valid shall be 0 outside REPORT; out_count shall keep its last value.
REQ-032 An illegal state encoding shall return to IDLE on the next edge.

Reset
REQ-033 reset=1 shall immediately force state=IDLE, in_ready=1, out_valid=0, out_count=0, total_count=0, ser_bit=0 and busy=0, with shift register, history and index cleared.
REQ-034 Asserting reset mid-SHIFT or mid-REPORT shall discard the word with no result produced.
REQ-035 Operation shall resume on the first rising edge of clk after reset falls.

Verification
REQ-036 Word 8'hDB, out_ready=1 -> out_count=2 exactly 8 cycles after acceptance; total_count=2.
REQ-037 Words 8'hFF, then 8'h0D, then 8'hB6 -> out_count=0, 1 and 1; total_count=2.
REQ-038 Word 8'h03 then 8'h40 (a match only if bits ran across the word boundary) -> out_count=0 for both.
REQ-039 Hold out_ready=0 for 5 cycles in REPORT -> out_valid and out_count stable, in_ready=0 and in_valid ignored throughout.
REQ-040 Pulse abort at SHIFT bit 4 of 8'hDB -> IDLE next cycle, no out_valid, total_count unchanged; 8'h0D afterwards -> out_count=1.
REQ-041 Assert reset mid-SHIFT -> all outputs take their reset values at once; bench checks reset values and that in_ready is 1 on the first cycle after release.

Source files
------------

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a parallel word, serializes it MSB first through a
// "1101" pattern detector (overlapping matches allowed, no carry-over between
// words), reports the per-word match count with valid/ready handshake and
// keeps a saturating running total of matches since reset.
module seq_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [15:0]      total_count,
    output logic             ser_bit,
    output logic             busy
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [2:0]       r_hist;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_out_count;
    logic [15:0]      r_total;

    logic [1:0]       w_state_nxt;
    logic             w_accept;
    logic             w_step;
    logic             w_last_bit;
    logic             w_match;
    logic [CW-1:0]    w_cnt_nxt;
    logic [16:0]      w_total_sum;
    logic [15:0]      w_total_sat;

    // Handshake and status outputs decode directly from the state register
    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_REPORT);
    assign busy        = (r_state == ST_SHIFT) || (r_state == ST_REPORT);
    assign ser_bit     = r_shreg[WIDTH-1];
    assign out_count   = r_out_count;
    assign total_count = r_total;

    // Abort wins over a new word offered in the same cycle
    assign w_accept    = (r_state == ST_IDLE) && in_valid && !abort;
    assign w_step      = (r_state == ST_SHIFT) && !abort;
    assign w_last_bit  = (r_idx == IW'(WIDTH - 1));

    // Detector: the three previous bits of this word plus the current bit
    assign w_match     = ({r_hist, ser_bit} == 4'b1101);
    assign w_cnt_nxt   = r_cnt + CW'(w_match);

    // Running total saturates instead of wrapping
    assign w_total_sum = {1'b0, r_total} + 17'(w_cnt_nxt);
    assign w_total_sat = w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];

    // Next-state selection; unknown encodings fall back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort)
                    w_state_nxt = ST_IDLE;
                else if (w_last_bit)
                    w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                if (abort || out_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Shift register, match history, bit index and per-word count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shreg <= '0;
            r_hist  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shreg <= in_data;
            r_hist  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
            r_hist  <= {r_hist[1:0], ser_bit};
            r_idx   <= r_idx + 1'b1;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Result capture on the last shifted bit, including a match on that bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_count <= '0;
            r_total     <= '0;
        end else if (w_step && w_last_bit) begin
            r_out_count <= w_cnt_nxt;
            r_total     <= w_total_sat;
        end
    end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed words, back-pressure,
// abort, reset mid-scan, random words and back-to-back throughput, all
// checked against a bit-window reference count.
module tb_seq_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic [15:0]   total_count;
    logic          ser_bit;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int exp_total = 0;

    seq_scan_ctrl #(.WIDTH(W), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .abort(abort),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_count(out_count),
        .total_count(total_count),
        .ser_bit(ser_bit),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Count every 4-bit window of the word equal to 1101 (overlaps allowed)
    function automatic int ref_count(input logic [W-1:0] w);
        int n;
        logic [W-1:0] t;
        n = 0;
        for (int p = 0; p <= W - 4; p++) begin
            t = w >> p;
            if (t[3:0] == 4'b1101) n++;
        end
        return n;
    endfunction

    function automatic int sat_add(input int t, input int c);
        return (t + c > 65535) ? 65535 : t + c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word from IDLE, wait for the result (bounded), consume it
    task automatic run_word(input logic [W-1:0] w, output int lat,
                            output int cnt, output int tot);
        in_valid  = 1'b1;
        in_data   = w;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= W + 4; c++) begin
            tick();
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        cnt = int'(out_count);
        tot = int'(total_count);
        if (lat >= 0) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; out_ready = 1'b0;
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_out_count: got %0d expected 0", out_count); end
        checks++; if (total_count !== 16'd0) begin errors++; $display("FAIL reset_total: got %0d expected 0", total_count); end
        checks++; if ({ser_bit, busy} !== 2'b00) begin errors++; $display("FAIL reset_ser_busy: got %b expected 00", {ser_bit, busy}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        exp_total = 0;
    endtask

    task automatic test_directed();
        logic [W-1:0] words [6];
        int lat, cnt, tot, e;
        words = '{8'hDB, 8'hFF, 8'h0D, 8'hB6, 8'h03, 8'h40};
        for (int i = 0; i < 6; i++) begin
            run_word(words[i], lat, cnt, tot);
            e = ref_count(words[i]);
            exp_total = sat_add(exp_total, e);
            checks++; if (lat != W) begin errors++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, W); end
            checks++; if (cnt != e) begin errors++; $display("FAIL dir_count[%0d] word %h: got %0d expected %0d", i, words[i], cnt, e); end
            checks++; if (tot != exp_total) begin errors++; $display("FAIL dir_total[%0d]: got %0d expected %0d", i, tot, exp_total); end
        end
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL dir_idle: got ready=%b busy=%b expected 1 0", in_ready, busy); end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [CW-1:0] held;
        bit bad;
        in_valid = 1'b1; in_data = 8'hDB; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= W + 4; c++) begin
            tick();
            if (out_valid) begin lat = c; break; end
        end
        exp_total = sat_add(exp_total, ref_count(8'hDB));
        checks++; if (lat != W) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", lat, W); end
        held = out_count;
        checks++; if (held !== CW'(2)) begin errors++; $display("FAIL bp_count: got %0d expected 2", held); end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = $urandom;
            tick();
            if (out_valid !== 1'b1 || out_count !== held || in_ready !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL bp_hold: got valid=%b count=%0d ready=%b expected 1 %0d 0", out_valid, out_count, in_ready, held); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy); end
        checks++; if (total_count !== 16'(exp_total)) begin errors++; $display("FAIL bp_total: got %0d expected %0d", total_count, exp_total); end
    endtask

    task automatic test_abort();
        int lat, cnt, tot;
        bit seen;
        // abort alone in IDLE does nothing
        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got ready=%b busy=%b expected 1 0", in_ready, busy); end
        // abort while bit 4 of 8'hDB is on the detector
        in_valid = 1'b1; in_data = 8'hDB; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_shift_idle: got busy=%b ready=%b valid=%b expected 0 1 0", busy, in_ready, out_valid); end
        seen = 1'b0;
        for (int c = 0; c < W + 2; c++) begin tick(); if (out_valid) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL abort_no_result: got out_valid=1 expected 0"); end
        checks++; if (total_count !== 16'(exp_total)) begin errors++; $display("FAIL abort_total: got %0d expected %0d", total_count, exp_total); end
        run_word(8'h0D, lat, cnt, tot);
        exp_total = sat_add(exp_total, 1);
        checks++; if (cnt != 1 || lat != W) begin errors++; $display("FAIL abort_after: got count=%0d lat=%0d expected 1 %0d", cnt, lat, W); end
        // abort in REPORT: result dropped, total already counted, out_count kept
        in_valid = 1'b1; in_data = 8'hDB; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= W + 4; c++) begin tick(); if (out_valid) begin lat = c; break; end end
        exp_total = sat_add(exp_total, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_report: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (total_count !== 16'(exp_total) || out_count !== CW'(2)) begin errors++; $display("FAIL abort_report_vals: got total=%0d count=%0d expected %0d 2", total_count, out_count, exp_total); end
    endtask

    task automatic test_reset_mid_shift();
        int lat, cnt, tot;
        in_valid = 1'b1; in_data = 8'hB6; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #1;
        reset = 1'b1;
        #1;
        exp_total = 0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ser_bit !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got ready=%b valid=%b busy=%b ser=%b expected 1 0 0 0", in_ready, out_valid, busy, ser_bit); end
        checks++; if (total_count !== 16'd0 || out_count !== '0) begin errors++; $display("FAIL rst_mid_counts: got total=%0d count=%0d expected 0 0", total_count, out_count); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got ready=%b busy=%b valid=%b expected 1 0 0", in_ready, busy, out_valid); end
        run_word(8'hDB, lat, cnt, tot);
        exp_total = sat_add(exp_total, 2);
        checks++; if (cnt != 2 || tot != exp_total || lat != W) begin errors++; $display("FAIL rst_resume: got count=%0d total=%0d lat=%0d expected 2 %0d %0d", cnt, tot, lat, exp_total, W); end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int lat, cnt, tot, e;
        for (int i = 0; i < 20; i++) begin
            w = W'($urandom);
            run_word(w, lat, cnt, tot);
            e = ref_count(w);
            exp_total = sat_add(exp_total, e);
            checks++; if (lat != W || cnt != e || tot != exp_total) begin errors++; $display("FAIL rand[%0d] word %h: got lat=%0d count=%0d total=%0d expected %0d %0d %0d", i, w, lat, cnt, tot, W, e, exp_total); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [4];
        int acc_t [$];
        int res [$];
        int idx, cyc;
        bit acc;
        for (int i = 0; i < 4; i++) words[i] = W'($urandom);
        words[0] = 8'hDB;
        idx = 0; cyc = 0;
        out_ready = 1'b1; in_valid = 1'b1; in_data = words[0];
        while (res.size() < 4 && cyc < 8 * (W + 2)) begin
            acc = in_ready && in_valid;
            tick();
            cyc++;
            if (acc) begin
                acc_t.push_back(cyc);
                idx++;
                if (idx < 4) in_data = words[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) res.push_back(int'(out_count));
        end
        in_valid = 1'b0;
        checks++; if (res.size() != 4 || acc_t.size() != 4) begin errors++; $display("FAIL b2b_done: got results=%0d accepts=%0d expected 4 4", res.size(), acc_t.size()); end
        for (int i = 1; i < acc_t.size(); i++) begin
            checks++; if (acc_t[i] - acc_t[i-1] != W + 2) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, acc_t[i] - acc_t[i-1], W + 2); end
        end
        for (int i = 0; i < res.size(); i++) begin
            exp_total = sat_add(exp_total, ref_count(words[i]));
            checks++; if (res[i] != ref_count(words[i])) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, res[i], ref_count(words[i])); end
        end
        tick();
        checks++; if (total_count !== 16'(exp_total)) begin errors++; $display("FAIL b2b_total: got %0d expected %0d", total_count, exp_total); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_abort();
        test_reset_mid_shift();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop in case a task never returns
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
